// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer: widths, op encodings
// (instr[14:12]), FSM states and the per-operation context latched at issue.
package mdu_seq_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned HLEN  = XLEN / 2;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    mdu_op_e op;
    logic    word;
    logic    neg_res;
    logic    neg_rem;
  } mdu_ctx_t;

  // W-variant results are sign-extended from bit 31
  function automatic logic [XLEN-1:0] word_sext(input logic [HLEN-1:0] v);
    return {{HLEN{v[HLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/writeback handshake bundle between decode, the MDU sequencer and writeback.
interface mdu_seq_if;
  import mdu_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    output in_ready, out_valid, out_result, busy
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor
// if it fits, and emit the quotient bit.
module mdu_div_step
  import mdu_seq_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  // When the subtraction succeeds the true difference is below the divisor, so it fits XLEN bits
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M sequencer: shift-add multiply and restoring divide on magnitudes,
// with a one-cycle path for divide-by-zero and signed overflow.
module mdu_seq
  import mdu_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mdu_seq_if.slave bus
);

  localparam int unsigned AW = 2 * XLEN;

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mdu_ctx_t         ctx, ctx_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [XLEN-1:0]  opb, opb_nxt;
  logic [XLEN-1:0]  result, result_nxt;
  logic             out_valid, in_ready, busy;

  mdu_op_e          op_in;
  logic             s1, s2, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, most_neg, fast_raw, fast_res;

  logic [XLEN:0]    mul_sum;
  logic [XLEN-1:0]  div_rem;
  logic             div_q;
  logic [AW-1:0]    acc_step, prod;
  logic [XLEN-1:0]  quo, rem, div_res, fin_res;

  mdu_div_step u_div_step (
    .rem_in  (acc[AW-1:XLEN]),
    .bit_in  (acc[XLEN-1]),
    .divisor (opb),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // Operand extension, magnitudes and fast-path detection from the offered operation
  always_comb begin
    op_in = mdu_op_e'(bus.in_op);
    s1    = op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    s2    = op_in inside {MDU_MULH, MDU_DIV, MDU_REM};
    if (bus.in_word) begin
      a_ext    = {{HLEN{s1 & bus.in_src1[HLEN-1]}}, bus.in_src1[HLEN-1:0]};
      b_ext    = {{HLEN{s2 & bus.in_src2[HLEN-1]}}, bus.in_src2[HLEN-1:0]};
      most_neg = {{(HLEN+1){1'b1}}, {(HLEN-1){1'b0}}};
    end else begin
      a_ext    = bus.in_src1;
      b_ext    = bus.in_src2;
      most_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = s1 & a_ext[XLEN-1];
    b_neg    = s2 & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = bus.in_op[2] && (b_ext == '0);
    div_ovf  = bus.in_op[2] && s1 && (a_ext == most_neg) && (b_ext == '1);
    if (bus.in_op[1]) fast_raw = div_zero ? a_ext : '0;
    else              fast_raw = div_zero ? '1 : a_ext;
    fast_res = bus.in_word ? word_sext(fast_raw[HLEN-1:0]) : fast_raw;
  end

  // One iteration of the active algorithm and the sign-fixed result it would yield
  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    acc_step = ctx.op[2] ? {div_rem, acc[XLEN-2:0], div_q} : {mul_sum, acc[XLEN-1:1]};
    prod     = ctx.neg_res ? -acc_step : acc_step;
    quo      = ctx.neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = ctx.neg_rem ? -acc_step[AW-1:XLEN] : acc_step[AW-1:XLEN];
    div_res  = ctx.op[1] ? rem : quo;
    if (ctx.op[2])
      fin_res = ctx.word ? word_sext(div_res[HLEN-1:0]) : div_res;
    else if (ctx.op == MDU_MUL)
      fin_res = ctx.word ? word_sext(prod[XLEN-1:HLEN]) : prod[XLEN-1:0];
    else
      fin_res = prod[AW-1:XLEN];
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ctx_nxt    = ctx;
    acc_nxt    = acc;
    opb_nxt    = opb;
    result_nxt = result;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          ctx_nxt.op      = op_in;
          ctx_nxt.word    = bus.in_word;
          ctx_nxt.neg_res = a_neg ^ b_neg;
          ctx_nxt.neg_rem = a_neg;
          if (div_zero || div_ovf) begin
            result_nxt = fast_res;
            state_nxt  = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = bus.in_word ? CNT_W'(HLEN) : CNT_W'(XLEN);
            // Word dividends are pre-aligned so their MSB is shifted in first
            if (bus.in_op[2]) begin
              acc_nxt = {{XLEN{1'b0}},
                         bus.in_word ? {a_mag[HLEN-1:0], {HLEN{1'b0}}} : a_mag};
              opb_nxt = b_mag;
            end else begin
              acc_nxt = {{XLEN{1'b0}}, b_mag};
              opb_nxt = a_mag;
            end
          end
        end
      end
      BUSY: begin
        acc_nxt = acc_step;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result_nxt = fin_res;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ctx       <= '0;
      acc       <= '0;
      opb       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ctx       <= ctx_nxt;
      acc       <= acc_nxt;
      opb       <= opb_nxt;
      result    <= result_nxt;
      out_valid <= (state_nxt == DONE);
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = result;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic results, latencies, fast paths,
// back-pressure, flush and asynchronous reset.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mdu_seq_if ifc ();

  mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [2:0] op, input logic w,
                      input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    ifc.in_op    = op;
    ifc.in_word  = w;
    ifc.in_src1  = a;
    ifc.in_src2  = b;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  // Latency counts clock edges from the handshake edge up to out_valid (bounded)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!ifc.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    send(op, w, a, b);
    wait_valid(lat);
    res = ifc.out_result;
    drain();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
    checks++; if (ifc.out_result !== 64'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", ifc.out_result); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [63:0] r;
    int lat;
    run_op(MDU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mul_7x-3 got=%h exp=ffffffffffffffeb", r); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL mul_latency got=%0d exp=65", lat); end
    checks++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin failures++; $display("FAIL mul_return_idle got=%b%b exp=10", ifc.in_ready, ifc.out_valid); end
    run_op(MDU_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulw_sext got=%h exp=fffffffffffffffe", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL mulw_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_mulh();
    logic [63:0] r;
    int lat;
    run_op(MDU_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mulh_minx2 got=%h exp=ffffffffffffffff", r); end
    run_op(MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mulhu_ones got=%h exp=fffffffffffffffe", r); end
    run_op(MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mulhsu_-1x2 got=%h exp=ffffffffffffffff", r); end
    run_op(MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    checks++; if (r !== 64'd1) begin failures++; $display("FAIL mulhu_onesx2 got=%h exp=1", r); end
  endtask

  task automatic test_div();
    logic [63:0] r;
    int lat;
    run_op(MDU_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL divw_-7/2 got=%h exp=fffffffffffffffd", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divw_latency got=%0d exp=33", lat); end
    run_op(MDU_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL remw_-7%%2 got=%h exp=ffffffffffffffff", r); end
    run_op(MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin failures++; $display("FAIL div_-100/7 got=%h exp=fffffffffffffff2", r); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL div_latency got=%0d exp=65", lat); end
    run_op(MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL rem_-100%%7 got=%h exp=fffffffffffffffe", r); end
  endtask

  task automatic test_fast_path();
    logic [63:0] r;
    int lat;
    run_op(MDU_DIV, 1'b0, 64'd100, 64'd0, r, lat);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL div_by_zero got=%h exp=ffffffffffffffff", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_by_zero_latency got=%0d exp=1", lat); end
    run_op(MDU_REM, 1'b0, 64'd100, 64'd0, r, lat);
    checks++; if (r !== 64'd100) begin failures++; $display("FAIL rem_by_zero got=%h exp=64", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL rem_by_zero_latency got=%0d exp=1", lat); end
    run_op(MDU_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_overflow got=%h exp=8000000000000000", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_overflow_latency got=%0d exp=1", lat); end
    run_op(MDU_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    checks++; if (r !== 64'd0) begin failures++; $display("FAIL rem_overflow got=%h exp=0", r); end
  endtask

  task automatic test_backpressure();
    int lat;
    send(MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL bp_latency got=%0d exp=65", lat); end
    // Offer another op while DONE: it must be ignored
    ifc.in_op    = MDU_MUL;
    ifc.in_src1  = 64'd3;
    ifc.in_src2  = 64'd3;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (ifc.out_valid !== 1'b1 || ifc.out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/fffffffffffffffe", i, ifc.out_valid, ifc.out_result);
      end
      checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, ifc.in_ready); end
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    drain();
    checks++; if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", ifc.in_ready, ifc.busy); end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int lat;
    logic seen;
    send(MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (ifc.busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", ifc.busy); end
    @(negedge clk);
    ifc.flush = 1'b1;
    @(posedge clk);
    #1 ifc.flush = 1'b0;
    checks++; if (ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_to_idle got=%b%b%b exp=010", ifc.busy, ifc.in_ready, ifc.out_valid);
    end
    // flush in the same cycle as an offer: nothing is accepted
    @(negedge clk);
    ifc.in_op    = MDU_MUL;
    ifc.in_word  = 1'b0;
    ifc.in_src1  = 64'd5;
    ifc.in_src2  = 64'd5;
    ifc.in_valid = 1'b1;
    ifc.flush    = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.flush    = 1'b0;
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL flush_beats_valid got=%b exp=0", ifc.busy); end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (ifc.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result got=%b exp=0", seen); end
    run_op(MDU_DIVU, 1'b0, 64'd1000, 64'd7, r, lat);
    checks++; if (r !== 64'd142) begin failures++; $display("FAIL post_flush_divu got=%0d exp=142", r); end
    checks++; if (lat !== 65) begin failures++; $display("FAIL post_flush_latency got=%0d exp=65", lat); end
    run_op(MDU_REMU, 1'b0, 64'd1000, 64'd7, r, lat);
    checks++; if (r !== 64'd6) begin failures++; $display("FAIL post_flush_remu got=%0d exp=6", r); end
  endtask

  task automatic test_async_rst();
    logic [63:0] r;
    int lat;
    send(MDU_MUL, 1'b0, 64'd5, 64'd6);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      failures++; $display("FAIL arst_ctrl got=%b%b%b exp=010", ifc.busy, ifc.in_ready, ifc.out_valid);
    end
    checks++; if (ifc.out_result !== 64'd0) begin failures++; $display("FAIL arst_result got=%h exp=0", ifc.out_result); end
    @(negedge clk);
    rst = 1'b0;
    run_op(MDU_MUL, 1'b0, 64'd5, 64'd6, r, lat);
    checks++; if (r !== 64'd30) begin failures++; $display("FAIL post_rst_mul got=%0d exp=30", r); end
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_op     = 3'd0;
    ifc.in_word   = 1'b0;
    ifc.in_src1   = 64'd0;
    ifc.in_src2   = 64'd0;
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
